// File: rtl/id_ex_register.sv
// ----------------------------------------------------------------------------
// id_ex_register
//
// Pipeline register between the decode (ID) and execute (EX) stages.
//
// Each rising edge performs exactly one action, highest priority first:
//   flush   : stage becomes a bubble (every field zero, valid low)
//   stall   : stage holds its contents unchanged
//   no-op   : data/index/funct/PC fields load, control fields and valid zero
//   load    : every field loads from ID, valid high
// Flush and no-op edges count as bubbles entering EX. The bubble counter
// saturates at its maximum value.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-low reset
//   stall_i             hold stage (load-use hazard)
//   flush_i             squash stage (taken branch)
//   No_op_i             load data but suppress control (ID-side no-op)
//   RegWrite_i ..       decoded control bits, ALUOp_i is 2 bits
//   RS1data_i ..        operands, immediate, PC (DATA_W each)
//   funct_i             {funct7, funct3}
//   RS1addr_i ..        register indices (5 bits each)
//   *_o                 registered copies of the inputs above
//   valid_o             EX holds a real instruction
//   bubble_cnt_o        saturating count of bubbles that entered EX
//
// All outputs come straight from flops: no combinational input-to-output path.
// ----------------------------------------------------------------------------
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              No_op_i,

    input  logic              RegWrite_i,
    input  logic              MemToReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              ALUSrc_i,
    input  logic [1:0]        ALUOp_i,

    input  logic [DATA_W-1:0] RS1data_i,
    input  logic [DATA_W-1:0] RS2data_i,
    input  logic [DATA_W-1:0] Imm_i,
    input  logic [DATA_W-1:0] PC_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,

    output logic              RegWrite_o,
    output logic              MemToReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              ALUSrc_o,
    output logic [1:0]        ALUOp_o,

    output logic [DATA_W-1:0] RS1data_o,
    output logic [DATA_W-1:0] RS2data_o,
    output logic [DATA_W-1:0] Imm_o,
    output logic [DATA_W-1:0] PC_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,

    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    // ------------------------------------------------------------------
    // Action decode. Exactly one of these is high per cycle.
    // ------------------------------------------------------------------
    logic doFlush;
    logic doHold;
    logic doNoOp;
    logic doLoad;
    logic isBubble;
    logic cntSat;

    always_comb begin
        doFlush  = flush_i;
        doHold   = !flush_i && stall_i;
        doNoOp   = !flush_i && !stall_i && No_op_i;
        doLoad   = !flush_i && !stall_i && !No_op_i;
        isBubble = doFlush || doNoOp;
        cntSat   = &bubble_cnt_o;
    end

    // ------------------------------------------------------------------
    // Control fields and valid. A no-op or flush clears them together so
    // control bits are never left set behind a low valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o <= 1'b0;
            MemToReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= 2'b00;
            valid_o    <= 1'b0;
        end else if (doFlush || doNoOp) begin
            RegWrite_o <= 1'b0;
            MemToReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            ALUSrc_o   <= 1'b0;
            ALUOp_o    <= 2'b00;
            valid_o    <= 1'b0;
        end else if (doLoad) begin
            RegWrite_o <= RegWrite_i;
            MemToReg_o <= MemToReg_i;
            MemRead_o  <= MemRead_i;
            MemWrite_o <= MemWrite_i;
            ALUSrc_o   <= ALUSrc_i;
            ALUOp_o    <= ALUOp_i;
            valid_o    <= 1'b1;
        end
        // doHold: keep everything
    end

    // ------------------------------------------------------------------
    // Data, index and funct fields. A no-op still carries these through so
    // EX sees the PC/indices of the squashed slot; only flush zeroes them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RS1data_o <= '0;
            RS2data_o <= '0;
            Imm_o     <= '0;
            PC_o      <= '0;
            funct_o   <= '0;
            RS1addr_o <= '0;
            RS2addr_o <= '0;
            RDaddr_o  <= '0;
        end else if (doFlush) begin
            RS1data_o <= '0;
            RS2data_o <= '0;
            Imm_o     <= '0;
            PC_o      <= '0;
            funct_o   <= '0;
            RS1addr_o <= '0;
            RS2addr_o <= '0;
            RDaddr_o  <= '0;
        end else if (!doHold) begin
            RS1data_o <= RS1data_i;
            RS2data_o <= RS2data_i;
            Imm_o     <= Imm_i;
            PC_o      <= PC_i;
            funct_o   <= funct_i;
            RS1addr_o <= RS1addr_i;
            RS2addr_o <= RS2addr_i;
            RDaddr_o  <= RDaddr_i;
        end
    end

    // ------------------------------------------------------------------
    // Bubble counter: counts flush and no-op edges, sticks at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (isBubble && !cntSat) begin
            bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// ----------------------------------------------------------------------------
// tb_id_ex_register
//
// Randomized plus directed stimulus for id_ex_register. The driver computes
// the expected stage contents for each edge from the priority rules and
// queues them; a monitor pops one entry per edge and compares the whole
// output set. Asynchronous reset is also checked between edges.
// ----------------------------------------------------------------------------
module tb_id_ex_register;

    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic          stall;
        logic          flush;
        logic          noOp;
        logic          regWrite;
        logic          memToReg;
        logic          memRead;
        logic          memWrite;
        logic          aluSrc;
        logic [1:0]    aluOp;
        logic [DW-1:0] rs1Data;
        logic [DW-1:0] rs2Data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [9:0]    funct;
        logic [4:0]    rs1Addr;
        logic [4:0]    rs2Addr;
        logic [4:0]    rdAddr;
    } inT;

    typedef struct packed {
        logic          regWrite;
        logic          memToReg;
        logic          memRead;
        logic          memWrite;
        logic          aluSrc;
        logic [1:0]    aluOp;
        logic [DW-1:0] rs1Data;
        logic [DW-1:0] rs2Data;
        logic [DW-1:0] imm;
        logic [DW-1:0] pc;
        logic [9:0]    funct;
        logic [4:0]    rs1Addr;
        logic [4:0]    rs2Addr;
        logic [4:0]    rdAddr;
        logic          valid;
        logic [CW-1:0] cnt;
    } outT;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    inT   in    = '0;
    outT  act;

    always #5 clk_i = ~clk_i;

    id_ex_register #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (in.stall),
        .flush_i      (in.flush),
        .No_op_i      (in.noOp),
        .RegWrite_i   (in.regWrite),
        .MemToReg_i   (in.memToReg),
        .MemRead_i    (in.memRead),
        .MemWrite_i   (in.memWrite),
        .ALUSrc_i     (in.aluSrc),
        .ALUOp_i      (in.aluOp),
        .RS1data_i    (in.rs1Data),
        .RS2data_i    (in.rs2Data),
        .Imm_i        (in.imm),
        .PC_i         (in.pc),
        .funct_i      (in.funct),
        .RS1addr_i    (in.rs1Addr),
        .RS2addr_i    (in.rs2Addr),
        .RDaddr_i     (in.rdAddr),
        .RegWrite_o   (act.regWrite),
        .MemToReg_o   (act.memToReg),
        .MemRead_o    (act.memRead),
        .MemWrite_o   (act.memWrite),
        .ALUSrc_o     (act.aluSrc),
        .ALUOp_o      (act.aluOp),
        .RS1data_o    (act.rs1Data),
        .RS2data_o    (act.rs2Data),
        .Imm_o        (act.imm),
        .PC_o         (act.pc),
        .funct_o      (act.funct),
        .RS1addr_o    (act.rs1Addr),
        .RS2addr_o    (act.rs2Addr),
        .RDaddr_o     (act.rdAddr),
        .valid_o      (act.valid),
        .bubble_cnt_o (act.cnt)
    );

    int  checks = 0;
    int  errors = 0;
    outT model  = '0;
    outT expQ[$];
    bit  stimDone = 1'b0;

    // Reference: what the stage should hold after one edge.
    function automatic outT modelNext(outT cur, inT v, logic rstN);
        outT n;
        int  c;
        n = cur;
        c = int'(cur.cnt) + 1;
        if (c > CNT_MAX) c = CNT_MAX;
        if (!rstN) begin
            n = '0;
        end else if (v.flush) begin
            n     = '0;
            n.cnt = CW'(c);
        end else if (!v.stall) begin
            n.rs1Data = v.rs1Data;
            n.rs2Data = v.rs2Data;
            n.imm     = v.imm;
            n.pc      = v.pc;
            n.funct   = v.funct;
            n.rs1Addr = v.rs1Addr;
            n.rs2Addr = v.rs2Addr;
            n.rdAddr  = v.rdAddr;
            if (v.noOp) begin
                n.regWrite = 0; n.memToReg = 0; n.memRead = 0;
                n.memWrite = 0; n.aluSrc = 0; n.aluOp = 2'b00;
                n.valid = 0;
                n.cnt   = CW'(c);
            end else begin
                n.regWrite = v.regWrite; n.memToReg = v.memToReg;
                n.memRead  = v.memRead;  n.memWrite = v.memWrite;
                n.aluSrc   = v.aluSrc;   n.aluOp    = v.aluOp;
                n.valid    = 1;
            end
        end
        return n;
    endfunction

    function automatic inT randIn(int stallPct, int flushPct, int noOpPct);
        inT v;
        v.stall    = ($urandom_range(99) < stallPct);
        v.flush    = ($urandom_range(99) < flushPct);
        v.noOp     = ($urandom_range(99) < noOpPct);
        v.regWrite = 1'($urandom);
        v.memToReg = 1'($urandom);
        v.memRead  = 1'($urandom);
        v.memWrite = 1'($urandom);
        v.aluSrc   = 1'($urandom);
        v.aluOp    = 2'($urandom);
        v.rs1Data  = $urandom;
        v.rs2Data  = $urandom;
        v.imm      = $urandom;
        v.pc       = $urandom;
        v.funct    = 10'($urandom);
        v.rs1Addr  = 5'($urandom);
        v.rs2Addr  = 5'($urandom);
        v.rdAddr   = 5'($urandom);
        return v;
    endfunction

    // Drive one cycle's inputs away from the active edge and queue the result.
    task automatic tick(input inT v, input logic rstN);
        @(negedge clk_i);
        rst_i = rstN;
        in    = v;
        model = modelNext(model, v, rstN);
        expQ.push_back(model);
    endtask

    task automatic checkZero(input string name);
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL %s: got %h want all zero", name, act);
        end
    endtask

    // Pulse reset low between edges; outputs must clear before the next edge.
    task automatic resetPulse(input string name);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1 checkZero(name);
        rst_i = 1'b1;
        model = '0;
    endtask

    // Monitor: the stage presents a result after every edge.
    initial begin
        outT e;
        forever begin
            @(posedge clk_i);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL stage@%0t: got %h want %h", $time, act, e);
                end
            end
        end
    end

    initial begin
        inT v;
        #1 checkZero("async_reset_at_start");

        // Control inputs are ignored while reset is held.
        v = randIn(0, 0, 0); v.stall = 1; v.flush = 1; v.noOp = 1;
        tick(v, 1'b0);
        tick(v, 1'b0);

        // R-type load straight out of reset.
        v = '0; v.regWrite = 1; v.aluOp = 2'b00; v.rs1Data = 32'h5; v.rdAddr = 5'd3;
        tick(v, 1'b1);

        // Load followed by a 3-cycle stall with changing inputs.
        v = '0; v.memRead = 1; v.memToReg = 1; v.aluSrc = 1; v.imm = 32'h8;
        v.rdAddr = 5'd9;
        tick(v, 1'b1);
        for (int i = 0; i < 3; i++) begin
            v = randIn(0, 0, 30); v.stall = 1;
            tick(v, 1'b1);
        end
        v = randIn(0, 0, 0);
        tick(v, 1'b1);

        // Store held by a stall, then flush and stall on the same edge.
        v = randIn(0, 0, 0); v.memWrite = 1;
        tick(v, 1'b1);
        v = randIn(0, 0, 0); v.stall = 1;
        tick(v, 1'b1);
        v = randIn(0, 0, 0); v.stall = 1; v.flush = 1;
        tick(v, 1'b1);

        // No-op load keeps data fields, drops control and valid.
        v = randIn(0, 0, 0); v.noOp = 1; v.regWrite = 1; v.rdAddr = 5'd7;
        v.pc = 32'h10;
        tick(v, 1'b1);

        // Random mix.
        for (int i = 0; i < 300; i++) begin
            v = randIn(25, 12, 15);
            tick(v, 1'b1);
        end

        // Reset pulse while valid, then a normal load.
        v = randIn(0, 0, 0);
        tick(v, 1'b1);
        resetPulse("async_reset_while_valid");
        v = randIn(0, 0, 0);
        tick(v, 1'b1);

        // Reset pulse in the middle of a stall: held content must not return.
        v = randIn(0, 0, 0); v.stall = 1;
        tick(v, 1'b1);
        resetPulse("async_reset_mid_stall");
        v = randIn(0, 0, 0); v.stall = 1;
        tick(v, 1'b1);
        tick(v, 1'b1);

        // 20 flushes from a cleared counter: counts to the max and sticks.
        for (int i = 0; i < 20; i++) begin
            v = randIn(50, 0, 50); v.flush = 1;
            tick(v, 1'b1);
        end
        v = randIn(0, 0, 100);
        tick(v, 1'b1);
        v = randIn(0, 0, 0);
        tick(v, 1'b1);

        stimDone = 1'b1;
    end

    initial begin
        wait (stimDone);
        repeat (3) @(posedge clk_i);
        #2;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending want 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
